logic_writer: RTL

Write-back end of the generation pipeline: accepts next-generation cell states one per cycle in raster order from the rule stage and packs them into memory words for the board memory's write port, mirroring the address layout the fetcher reads. Holds one completed word in a pending register so it can ride out memory-busy cycles when the fetcher owns the shared port, and asserts backpressure only when that register is also blocked. Supports double-buffered boards via a buffer select latched at start.

---
 rtl/logic_writer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/logic_writer.sv
// Write-back packer: collects raster-order cell states into WORD_W-bit words and
// issues them through a one-deep pending register that can wait out a busy port.
`timescale 1ns/1ps
module logic_writer #(
  parameter int WORD_W  = 32,
  parameter int BOARD_W = 128,
  parameter int BOARD_H = 128,
  parameter int ADDR_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              buf_sel_in,
  input  logic              cell_valid_in,
  input  logic              cell_in,
  input  logic              mem_busy_in,
  output logic              stall_out,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [WORD_W-1:0] data_out,
  output logic              done_out
);

  localparam int WPR         = BOARD_W / WORD_W;
  localparam int BOARD_WORDS = WPR * BOARD_H;
  localparam int WIDX_W      = (BOARD_WORDS > 1) ? $clog2(BOARD_WORDS) : 1;
  localparam int BIT_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(BOARD_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic               pend_v_q, pend_v_d;
  wr_t                pend_q, pend_d;

  logic               word_end, accept, complete;
  logic [WORD_W-1:0]  acc_set;

  // Stall only when a word is about to complete and its slot is still occupied.
  assign word_end  = (bit_q == LAST_BIT);
  assign stall_out = (state_q == RUN) && pend_v_q && mem_busy_in && word_end;
  assign accept    = (state_q == RUN) && cell_valid_in && !stall_out;
  assign complete  = accept && word_end;
  assign we_out    = pend_v_q && !mem_busy_in;
  assign addr_out  = pend_q.addr;
  assign data_out  = pend_q.data;
  assign done_out  = (state_q == DONE);

  always_comb begin
    acc_set        = acc_q;
    acc_set[bit_q] = cell_in;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    bit_d    = bit_q;
    widx_d   = widx_q;
    acc_d    = acc_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;

    case (state_q)
      IDLE: if (start_in) begin
        state_d = RUN;
        base_d  = buf_sel_in ? ADDR_W'(BOARD_WORDS) : '0;
        bit_d   = '0;
        widx_d  = '0;
        acc_d   = '0;
      end
      RUN: if (accept) begin
        if (word_end) begin
          bit_d  = '0;
          acc_d  = '0;
          widx_d = widx_q + 1'b1;
          if (widx_q == LAST_WORD) state_d = DRAIN;
        end else begin
          bit_d = bit_q + 1'b1;
          acc_d = acc_set;
        end
      end
      DRAIN: if (we_out) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A retiring write and a newly completed word may share an edge; the new word wins.
    if (complete) begin
      pend_v_d    = 1'b1;
      pend_d.addr = base_q + ADDR_W'(widx_q);
      pend_d.data = acc_set;
    end else if (we_out) begin
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      base_q   <= '0;
      bit_q    <= '0;
      widx_q   <= '0;
      acc_q    <= '0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      bit_q    <= bit_d;
      widx_q   <= widx_d;
      acc_q    <= acc_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end

endmodule
